multicycle_mips_core: RTL and testbench
=======================================

// Module: multicycle_mips_core
// PURPOSE
//  Multi-cycle successor to the single-cycle MIPS datapath. Runs a FETCH/DECODE/EXEC/MEM/WB FSM
//  with one shared ALU, and supports a data memory that inserts wait states (dmem_ready handshake).
//  Sits between the testbench instruction ROM and the data SRAM. rf_wdata/rf_we are exposed for checking.
// PARAMETERS
//  MEM_ADDR_W  7     data-memory word-address width
//  RF_DEPTH    32    register count; power of two, <=32; rs/rt/rd index = low log2(RF_DEPTH) bits
//  RESET_PC    0     PC value loaded at reset
// PORTS
//  clk         in   1           clock, posedge
//  rst_n       in   1           asynchronous reset, active-low
//  imem_addr   out  32          PC; instruction ROM is combinational
//  imem_rdata  in   32          instruction at imem_addr
//  dmem_cen    out  1           chip enable, active-low
//  dmem_wen    out  1           0 = write, 1 = read
//  dmem_oen    out  1           tied 0
//  dmem_addr   out  MEM_ADDR_W  word address = ALU result [MEM_ADDR_W+1:2]
//  dmem_wdata  out  32          rt data for sw
//  dmem_rdata  in   32          read data; valid while dmem_ready=1
//  dmem_ready  in   1           access completes in a cycle with cen=0 and ready=1
//  rf_we       out  1           register-file write strobe (WB)
//  rf_wdata    out  32          register-file write data
//  instr_done  out  1           1-cycle pulse on an instruction's last cycle
// BEHAVIOUR
//  - Reset (async): PC=RESET_PC, state=FETCH, all regs 0, dmem_cen=1, dmem_wen=1, rf_we=0,
//    instr_done=0, IR=0. Reset during MEM drops cen immediately; the access is abandoned.
//  - FETCH: IR<=imem_rdata.
//  - DECODE: A<=rs, B<=rt, PC+4 latched. Branch target = PC+4 + (sext(imm)<<2).
//  - EXEC: ALU computes.
//  - MEM: holds cen=0 until ready. lw captures dmem_rdata into MDR on the ready cycle.
//  - WB: rf_we=1 for exactly one cycle. Writes to $0 are discarded; $0 always reads 0.
//  - Instructions and CPI:
//      R-type            F-D-E-W      CPI 4
//      lw                F-D-E-M-W    CPI 5+waits
//      sw                F-D-E-M      CPI 4+waits
//      beq               F-D-E        CPI 3; PC<=target if A==B, else PC+4
//      j                 F-D          CPI 2; PC<={PC+4[31:28], IR[25:0], 2'b00}
//      unknown opcode    F-D          CPI 2; no state change except PC+4
//  - R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
//    Any other funct executes as a NOP and does not write.
//  - Arithmetic: 32-bit wrap, no overflow trap. Address bits [1:0] are ignored.
//  - PC updates only in an instruction's last cycle. instr_done is high in that same cycle.
//  - dmem_wen=0 only in MEM for sw; 1 everywhere else.
// CONFIGURATION
//  MC_MIPS_JAL_JR_EN defined:
//    jal (op 0x03): F-D-W, $31<=PC+4, PC<=jump target.
//    jr (R-type, funct 0x08): F-D, PC<=rs, no write.
//  MC_MIPS_JAL_JR_EN undefined: jal is an unknown opcode and jr is an unknown funct (NOP, PC+4).
// STRUCTURE
//  Package mips_pkg holds:
//    - opcode/funct localparams
//    - ALU control codes (ADD/SUB/AND/OR/SLT)
//    - FSM state encoding
//  One sub-module, mips_regfile (param RF_DEPTH):
//    - 2 async read ports
//    - 1 sync write port
//    - async reset clears all registers
//  FSM, ALU and PC logic stay in multicycle_mips_core.
// TESTING
//  1. Reset with RESET_PC=0x40 -> imem_addr=0x40, cen=1, wen=1, rf_we=0.
//     First instr_done appears 4 cycles after release for an R-type.
//  2. addi-free sequence: lw $1,0($0) with mem[0]=5; lw $2,4($0) with mem[1]=7; add $3,$1,$2
//     -> rf_wdata=12 with rf_we=1; slt $4,$2,$1 -> 0; sub $5,$1,$2 -> 0xFFFFFFFE.
//  3. sw $3,8($0) with ready held low 3 cycles -> cen=0, wen=0, addr=2, wdata=12 held
//     for all 4 cycles; PC advances only after ready.
//  4. beq with equal regs and imm=-1 -> PC=PC (self loop).
//     Unequal regs -> PC+4; 3 cycles each.
//  5. j 0x100 -> PC=0x400 after 2 cycles. Writes to $0 -> $0 reads 0.
//  6. With MC_MIPS_JAL_JR_EN: jal at 0x10 -> $31=0x14, then jr $31 returns to 0x14.
//     Without it: both act as NOPs, PC+4.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the multi-cycle MIPS core: opcode and funct
//   encodings, ALU control codes, FSM state encoding and the ALU itself.
//   The jal/jr encodings are only decoded when MC_MIPS_JAL_JR_EN is defined.
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  // FSM states
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  // True for the funct codes that produce a register result.
  function automatic logic fn_is_alu(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic logic [2:0] fn_to_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // 32-bit wrapping ALU; slt compares as two's complement.
  function automatic logic [31:0] alu(input logic [2:0]  ctrl,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (ctrl)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'd0, (sa < sb)};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile
//   Register file: two asynchronous read ports, one synchronous write port.
//   Register 0 is hardwired to zero (writes to it are dropped).
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset (clears all)
//   i_raddr1/o_rdata1      read port 1
//   i_raddr2/o_rdata2      read port 2
//   i_we/i_waddr/i_wdata   write port
module mips_regfile #(
  parameter int RF_DEPTH = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [$clog2(RF_DEPTH)-1:0] i_raddr1,
  output logic [31:0]                 o_rdata1,
  input  logic [$clog2(RF_DEPTH)-1:0] i_raddr2,
  output logic [31:0]                 o_rdata2,
  input  logic                        i_we,
  input  logic [$clog2(RF_DEPTH)-1:0] i_waddr,
  input  logic [31:0]                 i_wdata
);

  logic [31:0] r_regs [RF_DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? 32'd0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? 32'd0 : r_regs[i_raddr2];

endmodule

// File: rtl/multicycle_mips_core.sv
// multicycle_mips_core
//   Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB FSM sharing one ALU.
//   The data-memory access in MEM is held until dmem_ready.
//   Optional feature macro: MC_MIPS_JAL_JR_EN adds jal (F-D-W) and jr (F-D).
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr/rdata   PC out, combinational instruction in
//   dmem_*            data SRAM (cen/wen active-low, oen tied 0, ready handshake)
//   rf_we, rf_wdata   register-file write strobe and data (WB cycle)
//   instr_done        pulse on each instruction's last cycle
module multicycle_mips_core
  import mips_pkg::*;
#(
  parameter int          MEM_ADDR_W = 7,
  parameter int          RF_DEPTH   = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [31:0]           imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic                  dmem_cen,
  output logic                  dmem_wen,
  output logic                  dmem_oen,
  output logic [MEM_ADDR_W-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  rf_we,
  output logic [31:0]           rf_wdata,
  output logic                  instr_done
);

  localparam int RF_AW = $clog2(RF_DEPTH);

  logic [2:0]       r_state, w_next_state;
  logic [31:0]      r_pc, r_ir, r_a, r_b, r_pc4, r_target, r_aluout, r_mdr;
  logic [31:0]      w_pc4, w_sext, w_jtarget, w_pc_next;
  logic [31:0]      w_rs_data, w_rt_data;
  logic [31:0]      w_alu_a, w_alu_b, w_alu_y;
  logic [2:0]       w_alu_ctrl;
  logic             w_done;
  logic [5:0]       w_op, w_funct;
  logic [RF_AW-1:0] w_rs, w_rt, w_rd, w_waddr;
  logic             w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_jal, w_is_jr;

  assign w_op      = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_rs      = r_ir[21 +: RF_AW];
  assign w_rt      = r_ir[16 +: RF_AW];
  assign w_rd      = r_ir[11 +: RF_AW];
  assign w_sext    = {{16{r_ir[15]}}, r_ir[15:0]};
  // PC only moves on an instruction's last cycle, so PC+4 is stable throughout.
  assign w_pc4     = r_pc + 32'd4;
  assign w_jtarget = {w_pc4[31:28], r_ir[25:0], 2'b00};

`ifdef MC_MIPS_JAL_JR_EN
  assign w_is_jal = (w_op == OP_JAL);
  assign w_is_jr  = (w_op == OP_RTYPE) && (w_funct == FN_JR);
`else
  assign w_is_jal = 1'b0;
  assign w_is_jr  = 1'b0;
`endif

  // Every R-type except jr runs F-D-E-W; unknown functs just skip the write.
  assign w_is_r   = (w_op == OP_RTYPE) && !w_is_jr;
  assign w_is_lw  = (w_op == OP_LW);
  assign w_is_sw  = (w_op == OP_SW);
  assign w_is_beq = (w_op == OP_BEQ);
  assign w_is_j   = (w_op == OP_J);

  assign w_alu_y = alu(w_alu_ctrl, w_alu_a, w_alu_b);

  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    w_pc_next    = r_pc;
    w_alu_a      = r_a;
    w_alu_b      = r_b;
    w_alu_ctrl   = ALU_ADD;
    case (r_state)
      S_FETCH: w_next_state = S_DECODE;
      S_DECODE: begin
        // ALU is idle here, so it forms the branch target.
        w_alu_a = w_pc4;
        w_alu_b = {w_sext[29:0], 2'b00};
        if (w_is_r || w_is_lw || w_is_sw || w_is_beq) begin
          w_next_state = S_EXEC;
        end else if (w_is_jal) begin
          w_next_state = S_WB;
        end else begin
          w_done    = 1'b1;
          w_pc_next = w_is_j ? w_jtarget : (w_is_jr ? w_rs_data : w_pc4);
        end
      end
      S_EXEC: begin
        if (w_is_lw || w_is_sw) begin
          w_alu_b      = w_sext;
          w_next_state = S_MEM;
        end else if (w_is_beq) begin
          w_alu_ctrl = ALU_SUB;
          w_done     = 1'b1;
          w_pc_next  = (w_alu_y == 32'd0) ? r_target : r_pc4;
        end else begin
          w_alu_ctrl   = fn_to_alu(w_funct);
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (w_is_lw) begin
            w_next_state = S_WB;
          end else begin
            w_done    = 1'b1;
            w_pc_next = r_pc4;
          end
        end
      end
      S_WB: begin
        w_done    = 1'b1;
        w_pc_next = w_is_jal ? w_jtarget : r_pc4;
      end
      default: w_next_state = S_FETCH;
    endcase
    if (w_done) w_next_state = S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_pc4    <= '0;
      r_target <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_done) r_pc <= w_pc_next;
      case (r_state)
        S_FETCH:  r_ir <= imem_rdata;
        S_DECODE: begin
          r_a      <= w_rs_data;
          r_b      <= w_rt_data;
          r_pc4    <= w_pc4;
          r_target <= w_alu_y;
        end
        S_EXEC:   r_aluout <= w_alu_y;
        S_MEM:    if (dmem_ready && w_is_lw) r_mdr <= dmem_rdata;
        default:  ;
      endcase
    end
  end

  // Memory controls decode straight from state so reset releases cen at once.
  assign imem_addr  = r_pc;
  assign dmem_cen   = (r_state != S_MEM);
  assign dmem_wen   = !((r_state == S_MEM) && w_is_sw);
  assign dmem_oen   = 1'b0;
  assign dmem_addr  = r_aluout[MEM_ADDR_W+1:2];
  assign dmem_wdata = r_b;

  assign rf_we      = (r_state == S_WB) &&
                      (w_is_lw || w_is_jal || (w_is_r && fn_is_alu(w_funct)));
  assign rf_wdata   = w_is_lw ? r_mdr : (w_is_jal ? r_pc4 : r_aluout);
  assign w_waddr    = w_is_lw ? w_rt : (w_is_jal ? {RF_AW{1'b1}} : w_rd);
  assign instr_done = w_done;

  mips_regfile #(.RF_DEPTH(RF_DEPTH)) u_rf (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_raddr1 (w_rs),
    .o_rdata1 (w_rs_data),
    .i_raddr2 (w_rt),
    .o_rdata2 (w_rt_data),
    .i_we     (rf_we),
    .i_waddr  (w_waddr),
    .i_wdata  (rf_wdata)
  );

endmodule

// File: tb/tb_multicycle_mips_core.sv
// tb_multicycle_mips_core
//   Directed program for multicycle_mips_core (RESET_PC = 0x40) with a
//   combinational instruction ROM and a data SRAM model whose ready can be
//   held low for a programmable number of cycles per access.
module tb_multicycle_mips_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_cen, dmem_wen, dmem_oen, dmem_ready;
  logic [6:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        rf_we, instr_done;
  logic [31:0] rf_wdata;

  logic [31:0] rom  [0:1023];
  logic [31:0] dmem [0:127];
  int          wait_n = 0;
  int          wcnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  multicycle_mips_core #(
    .MEM_ADDR_W (7),
    .RF_DEPTH   (32),
    .RESET_PC   (32'h40)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .dmem_cen   (dmem_cen),
    .dmem_wen   (dmem_wen),
    .dmem_oen   (dmem_oen),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .rf_we      (rf_we),
    .rf_wdata   (rf_wdata),
    .instr_done (instr_done)
  );

  assign imem_rdata = rom[imem_addr[11:2]];
  assign dmem_rdata = dmem[dmem_addr];
  assign dmem_ready = !dmem_cen && (wcnt >= wait_n);

  always @(posedge clk) begin
    if (dmem_cen || dmem_ready) wcnt <= 0;
    else                        wcnt <= wcnt + 1;
    if (!dmem_cen && dmem_ready && !dmem_wen) dmem[dmem_addr] <= dmem_wdata;
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called in an instruction's FETCH cycle (1 time unit after the edge);
  // returns in the next instruction's FETCH cycle.
  task automatic run_instr(input string tag, input int exp_cyc, input logic [31:0] exp_pc,
                           input bit exp_we, input logic [31:0] exp_wd, input int exp_mem);
    int          cyc = 0;
    int          memc = 0;
    bit          we_seen = 1'b0;
    bit          done_seen = 1'b0;
    bit          pc_moved = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] pc0;
    pc0 = imem_addr;
    while (!done_seen && cyc < 40) begin
      cyc++;
      if (imem_addr !== pc0) pc_moved = 1'b1;
      if (!dmem_cen) memc++;
      if (rf_we) begin
        we_seen = 1'b1;
        wd      = rf_wdata;
      end
      if (instr_done) done_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk({tag, " done"},     32'(done_seen), 32'd1);
    chk({tag, " cycles"},   32'(cyc),       32'(exp_cyc));
    chk({tag, " next_pc"},  imem_addr,      exp_pc);
    chk({tag, " rf_we"},    32'(we_seen),   32'(exp_we));
    if (exp_we) chk({tag, " rf_wdata"}, wd, exp_wd);
    chk({tag, " mem_cyc"},  32'(memc),      32'(exp_mem));
    chk({tag, " pc_held"},  32'(pc_moved),  32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hFC00_0000;  // opcode 0x3F: unknown
    for (int i = 0; i < 128; i++) dmem[i] = 32'd0;
    dmem[0] = 32'd5;
    dmem[1] = 32'd7;

    rom[32'h40 >> 2]  = enc_r(5'd0, 5'd0, 5'd6, 6'h20);        // add $6,$0,$0
    rom[32'h44 >> 2]  = enc_i(6'h23, 5'd0, 5'd1, 16'd0);       // lw  $1,0($0)
    rom[32'h48 >> 2]  = enc_i(6'h23, 5'd0, 5'd2, 16'd4);       // lw  $2,4($0)
    rom[32'h4C >> 2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);        // add $3,$1,$2
    rom[32'h50 >> 2]  = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);        // slt $4,$2,$1
    rom[32'h54 >> 2]  = enc_r(5'd1, 5'd2, 5'd5, 6'h22);        // sub $5,$1,$2
    rom[32'h58 >> 2]  = enc_r(5'd5, 5'd1, 5'd7, 6'h2A);        // slt $7,$5,$1
    rom[32'h5C >> 2]  = enc_r(5'd5, 5'd2, 5'd8, 6'h24);        // and $8,$5,$2
    rom[32'h60 >> 2]  = enc_r(5'd1, 5'd2, 5'd9, 6'h25);        // or  $9,$1,$2
    rom[32'h64 >> 2]  = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);       // sw  $3,8($0)
    rom[32'h68 >> 2]  = enc_i(6'h23, 5'd0, 5'd10, 16'd8);      // lw  $10,8($0)
    rom[32'h6C >> 2]  = enc_r(5'd1, 5'd2, 5'd0, 6'h20);        // add $0,$1,$2
    rom[32'h70 >> 2]  = enc_r(5'd0, 5'd0, 5'd11, 6'h20);       // add $11,$0,$0
    rom[32'h74 >> 2]  = enc_i(6'h04, 5'd1, 5'd2, 16'd5);       // beq $1,$2,+5
    rom[32'h78 >> 2]  = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);    // beq $1,$1,-1
    rom[32'h404 >> 2] = enc_r(5'd1, 5'd2, 5'd13, 6'h00);       // funct 0: NOP
    rom[32'h408 >> 2] = enc_j(6'h02, 26'h4);                   // j 0x10
    rom[32'h10 >> 2]  = enc_j(6'h03, 26'h80);                  // jal 0x200
    rom[32'h200 >> 2] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);       // jr $31
    rom[32'h14 >> 2]  = enc_r(5'd31, 5'd0, 5'd12, 6'h20);      // add $12,$31,$0
    rom[32'h18 >> 2]  = enc_r(5'd31, 5'd0, 5'd0, 6'h08);       // jr $31

    repeat (3) @(posedge clk);
    #1;
    chk("rst imem_addr", imem_addr, 32'h40);
    chk("rst cen", 32'(dmem_cen), 32'd1);
    chk("rst wen", 32'(dmem_wen), 32'd1);
    chk("rst oen", 32'(dmem_oen), 32'd0);
    chk("rst rf_we", 32'(rf_we), 32'd0);
    chk("rst done", 32'(instr_done), 32'd0);
    rst_n = 1'b1;

    run_instr("add6", 4, 32'h44, 1'b1, 32'd0, 0);
    run_instr("lw1", 5, 32'h48, 1'b1, 32'd5, 1);
    wait_n = 2;
    run_instr("lw2_wait", 7, 32'h4C, 1'b1, 32'd7, 3);
    wait_n = 0;
    run_instr("add3", 4, 32'h50, 1'b1, 32'd12, 0);
    run_instr("slt4", 4, 32'h54, 1'b1, 32'd0, 0);
    run_instr("sub5", 4, 32'h58, 1'b1, 32'hFFFF_FFFE, 0);
    run_instr("slt7_signed", 4, 32'h5C, 1'b1, 32'd1, 0);
    run_instr("and8", 4, 32'h60, 1'b1, 32'd6, 0);
    run_instr("or9", 4, 32'h64, 1'b1, 32'd7, 0);

    // sw with ready held low for 3 cycles: F, D, E then 4 MEM cycles
    wait_n = 3;
    repeat (3) begin
      chk("sw pre cen", 32'(dmem_cen), 32'd1);
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 4; k++) begin
      chk("sw cen", 32'(dmem_cen), 32'd0);
      chk("sw wen", 32'(dmem_wen), 32'd0);
      chk("sw addr", 32'(dmem_addr), 32'd2);
      chk("sw wdata", dmem_wdata, 32'd12);
      chk("sw pc held", imem_addr, 32'h64);
      chk("sw done", 32'(instr_done), 32'(k == 3));
      @(posedge clk);
      #1;
    end
    chk("sw next_pc", imem_addr, 32'h68);
    chk("sw idle cen", 32'(dmem_cen), 32'd1);
    wait_n = 0;

    run_instr("lw10_readback", 5, 32'h6C, 1'b1, 32'd12, 1);
    run_instr("add_to_r0", 4, 32'h70, 1'b1, 32'd12, 0);
    run_instr("add11_r0_reads0", 4, 32'h74, 1'b1, 32'd0, 0);
    run_instr("beq_ne", 3, 32'h78, 1'b0, 32'd0, 0);
    run_instr("beq_self", 3, 32'h78, 1'b0, 32'd0, 0);
    rom[32'h78 >> 2] = enc_j(6'h02, 26'h100);                  // j 0x400
    run_instr("j_400", 2, 32'h400, 1'b0, 32'd0, 0);
    run_instr("unk_op", 2, 32'h404, 1'b0, 32'd0, 0);
    run_instr("unk_funct", 4, 32'h408, 1'b0, 32'd0, 0);
    run_instr("j_10", 2, 32'h10, 1'b0, 32'd0, 0);
`ifdef MC_MIPS_JAL_JR_EN
    run_instr("jal", 3, 32'h200, 1'b1, 32'h14, 0);
    run_instr("jr", 2, 32'h14, 1'b0, 32'd0, 0);
    run_instr("add12_r31", 4, 32'h18, 1'b1, 32'h14, 0);
    rom[32'h18 >> 2] = enc_i(6'h23, 5'd0, 5'd1, 16'd0);
`else
    run_instr("jal_nop", 2, 32'h14, 1'b0, 32'd0, 0);
    run_instr("add12_r31", 4, 32'h18, 1'b1, 32'd0, 0);
    run_instr("jr_nop", 4, 32'h1C, 1'b0, 32'd0, 0);
    rom[32'h1C >> 2] = enc_i(6'h23, 5'd0, 5'd1, 16'd0);
`endif

    // Reset in the middle of a stalled lw abandons the access at once.
    wait_n = 5;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mem stall cen", 32'(dmem_cen), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst in mem cen", 32'(dmem_cen), 32'd1);
    chk("rst in mem wen", 32'(dmem_wen), 32'd1);
    chk("rst in mem pc", imem_addr, 32'h40);
    chk("rst in mem rf_we", 32'(rf_we), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
